// File: rtl/kt_tour_checker_if.sv
// Solver-to-checker stream bundle: one tour is one contiguous in_valid burst; the
// checker returns a single-cycle verdict strobe plus status.
interface kt_tour_checker_if #(
    parameter int COORD_W = 3,
    parameter int MOVE_W  = 5
);
    // in_valid is a push-only strobe with no backpressure: while collecting, every
    // cycle with in_valid high is one beat. chk_valid qualifies chk_pass/err_*.
    logic               in_valid;
    logic [MOVE_W-1:0]  move_in;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               chk_valid;
    logic               chk_pass;
    logic [2:0]         err_code;
    logic [MOVE_W-1:0]  err_step;
    logic               busy;
    logic [1:0]         dbg_state;

    modport master (
        output in_valid, move_in, in_x, in_y,
        input  chk_valid, chk_pass, err_code, err_step, busy, dbg_state
    );

    modport slave (
        input  in_valid, move_in, in_x, in_y,
        output chk_valid, chk_pass, err_code, err_step, busy, dbg_state
    );
endinterface

// File: rtl/kt_tour_checker.sv
// Captures one knight's tour of BOARD*BOARD beats and reports the first error:
// move-number sequence, coordinate range, knight-jump legality and revisits.
module kt_tour_checker #(
    parameter int BOARD   = 5,
    parameter int COORD_W = 3,
    parameter int MOVE_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    kt_tour_checker_if.slave bus
);
    localparam int NSQ   = BOARD * BOARD;
    localparam int IDX_W = (NSQ > 1) ? $clog2(NSQ) : 1;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SEQ   = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_JUMP  = 3'd3;
    localparam logic [2:0] ERR_REVIS = 3'd4;
    localparam logic [2:0] ERR_SHORT = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [MOVE_W-1:0]      beat_cnt;
    logic [COORD_W-1:0]     prev_x;
    logic [COORD_W-1:0]     prev_y;
    // Padded to a power of two so any in-range index is always addressable.
    logic [(1<<IDX_W)-1:0]  visited;
    logic [2:0]             err_lat;
    logic [MOVE_W-1:0]      step_lat;

    logic [2:0]             code_q;
    logic [MOVE_W-1:0]      step_q;
    logic                   pass_q;

    logic                   consume;
    logic                   is_last;
    logic [MOVE_W-1:0]      beat_k;
    logic                   seq_err;
    logic                   range_err;
    logic                   jump_ok;
    logic [IDX_W-1:0]       sq_idx;
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic [COORD_W:0]       adx;
    logic [COORD_W:0]       ady;
    logic [2:0]             beat_err;
    logic [2:0]             err_nxt;
    logic [MOVE_W-1:0]      step_nxt;

    // Per-beat checks; the beat under test is index beat_cnt+1.
    always_comb begin
        consume   = bus.in_valid && ((state == IDLE) || (state == COLLECT));
        beat_k    = beat_cnt + MOVE_W'(1);
        is_last   = (beat_k == MOVE_W'(NSQ));
        seq_err   = (bus.move_in != beat_k);
        range_err = (bus.in_x >= COORD_W'(BOARD)) || (bus.in_y >= COORD_W'(BOARD));
        sq_idx    = IDX_W'(bus.in_y) * IDX_W'(BOARD) + IDX_W'(bus.in_x);

        // One extra bit keeps the difference exact: no wrap-around between edges.
        dx  = $signed({1'b0, bus.in_x}) - $signed({1'b0, prev_x});
        dy  = $signed({1'b0, bus.in_y}) - $signed({1'b0, prev_y});
        adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        jump_ok = ((adx == (COORD_W+1)'(1)) && (ady == (COORD_W+1)'(2))) ||
                  ((adx == (COORD_W+1)'(2)) && (ady == (COORD_W+1)'(1)));

        beat_err = ERR_NONE;
        if (seq_err) begin
            beat_err = ERR_SEQ;
        end else if (range_err) begin
            beat_err = ERR_RANGE;
        end else if ((beat_cnt != '0) && !jump_ok) begin
            beat_err = ERR_JUMP;
        end else if (visited[sq_idx]) begin
            beat_err = ERR_REVIS;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_lat;
        step_nxt  = step_lat;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_nxt = is_last ? REPORT : COLLECT;
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    state_nxt = is_last ? REPORT : COLLECT;
                end else begin
                    state_nxt = REPORT;
                    if (err_lat == ERR_NONE) begin
                        err_nxt  = ERR_SHORT;
                        step_nxt = beat_k;
                    end
                end
            end
            REPORT: begin
                state_nxt = bus.in_valid ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!bus.in_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Only the first failing beat of a tour is latched.
        if (consume && (err_lat == ERR_NONE) && (beat_err != ERR_NONE)) begin
            err_nxt  = beat_err;
            step_nxt = beat_k;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            prev_x   <= '0;
            prev_y   <= '0;
            visited  <= '0;
            err_lat  <= ERR_NONE;
            step_lat <= '0;
            code_q   <= ERR_NONE;
            step_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == IDLE) begin
                beat_cnt <= '0;
                prev_x   <= '0;
                prev_y   <= '0;
                visited  <= '0;
                err_lat  <= ERR_NONE;
                step_lat <= '0;
            end else begin
                err_lat  <= err_nxt;
                step_lat <= step_nxt;
                if (consume) begin
                    beat_cnt <= beat_k;
                    prev_x   <= bus.in_x;
                    prev_y   <= bus.in_y;
                    if (!range_err) visited[sq_idx] <= 1'b1;
                end
            end
            // Verdict registers hold until the next tour reaches REPORT.
            if (state_nxt == REPORT) begin
                code_q <= err_nxt;
                step_q <= step_nxt;
                pass_q <= (err_nxt == ERR_NONE);
            end
        end
    end

    assign bus.chk_valid = (state == REPORT);
    assign bus.chk_pass  = pass_q;
    assign bus.err_code  = code_q;
    assign bus.err_step  = step_q;
    assign bus.busy      = (state != IDLE) || bus.in_valid;
    assign bus.dbg_state = state;
endmodule
